computational_unit_param: RTL
=============================

Name: computational_unit_param

Overview:
- Parametrised next-generation computational unit for the team's small microprocessor datapath.
- Width generalised from 4 bits to DATA_W bits.
- Multiply becomes a multi-cycle shift-add engine with a busy/done handshake; adds a carry/borrow flag.
- Sits between instruction decoder (source_sel, reg_en, selects, function nibble) and data memory/IO; drives data_bus, o_reg and from_CU.

Parameters:
- DATA_W, 4, datapath width of every register, data_bus, i_pins, dm.
- MUL_CYC, DATA_W, multiply iterations; must equal DATA_W (one partial-product bit per cycle).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- i_pins  in  DATA_W  external input pins
- dm  in  DATA_W  data-memory read data
- ir_nibble  in  4  pm immediate data; [2:0] ALU function, [3] function modifier
- source_sel  in  4  data_bus source select
- reg_en  in  9  write enables: 0 x0, 1 x1, 2 y0, 3 y1, 4 r/flags, 5 m, 6 i, 7 unused, 8 o_reg
- i_sel  in  1  0: i<=data_bus, 1: i<=i+m
- x_sel, y_sel  in  1 each  ALU operand selects (0: x0/y0, 1: x1/y1)
- acc_mode  in  1  y1 write accumulates (y1<=y1+data_bus)
- data_bus  out  DATA_W  internal bus
- x0,x1,y0,y1,r,m,i,o_reg  out  DATA_W each  architectural registers
- r_eq_0  out  1  zero flag of last r write
- r_carry  out  1  carry (add) / borrow (sub) of last r write
- from_CU  out  2*DATA_W  {x1,x0}
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse when multiply result written to r

Behaviour:
- Reset (async): all registers 0, r_eq_0=1, r_carry=0, busy=0, done=0, multiplier state cleared; a multiply in flight is aborted, r not written.
- data_bus (comb): source_sel 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm, 8 zero-extended ir_nibble, 9 i_pins, 10-15 all zero.
- Register writes at clk edge when enable set; otherwise hold. x0,x1,y0,m,o_reg <= data_bus.
- i: i_sel=0 -> data_bus; i_sel=1 -> (i+m) mod 2^DATA_W.
- y1: acc_mode=1 -> (y1+data_bus) mod 2^DATA_W; else data_bus.
- ALU (x,y selected), single-cycle functions written on reg_en[4]:
  - 000: ir_nibble[3]=0 -> -x; =1 -> r (hold).
  - 001: x-y; r_carry = borrow (x<y).
  - 010: x+y; r_carry = carry-out.
  - 101: x^y. 110: x&y.
  - 111: ir_nibble[3]=0 -> ~x; =1 -> r.
  - r_carry cleared by all non add/sub functions.
- r_eq_0 updated with r on every r write: 1 iff written value is 0.
- Multiply (011 hi half, 100 lo half):
  - Starts when reg_en[4]=1 and busy=0; latches x, y and hi/lo choice.
  - busy=1 from next cycle for MUL_CYC cycles; one shift-add step per cycle into a 2*DATA_W accumulator.
  - On final step: r <= product[2W-1:W] or [W-1:0], r_eq_0 updated, r_carry=0, done=1 for that cycle, busy falls.
  - Start at edge N -> r valid after edge N+MUL_CYC.
- While busy, reg_en[4] is ignored (no r write, no new start); other register writes proceed normally.
- Operand registers changing mid-multiply do not affect the result.

Decomposition:
- Shared package cu_pkg:
  - ALU function codes.
  - source_sel codes.
  - reg_en bit indices.
  - Multiplier state encoding (IDLE, RUN).
- Sub-module seq_multiplier (DATA_W): start/busy/done, operand latches, shift-add accumulator, iteration counter.

Test Plan:
- Reset mid-run: start 7*6, assert reset at cycle 2 -> busy=0, r=0, r_eq_0=1, no done pulse.
- Load x0=3 from pm (source_sel=8), y0=9, function 010 -> r=0xC, r_carry=0; x0=9,y0=9 add -> r=2, r_carry=1.
- function 001 with x0=2, y0=5 -> r=0xD, r_carry=1; x0=5, y0=5 -> r=0, r_eq_0=1.
- Multiply hi: x0=7, y0=6, function 011 -> busy 4 cycles, done pulse, r=0x2. Function 100 -> r=0xA. reg_en[4] pulses while busy -> ignored.
- i_sel=1, i=0xE, m=3 -> i=1 (wrap). acc_mode: y1=0xF, data_bus=2 -> y1=1.
- source_sel 10..15 -> data_bus=0. from_CU = {x1,x0} = 0x5A after x1=5, x0=0xA. DATA_W=8 run: 200*3 -> hi=0x02, lo=0x58.

Source files
------------

// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg
// Shared encodings for the parametrised computational unit:
//   - ALU function codes (ir_nibble[2:0])
//   - data_bus source select codes (source_sel)
//   - reg_en bit indices
//   - sequential multiplier state encoding
// -----------------------------------------------------------------------------
package cu_pkg;

    // ALU function codes
    localparam logic [2:0] FN_NEG   = 3'b000;  // -x, or hold r when ir_nibble[3]=1
    localparam logic [2:0] FN_SUB   = 3'b001;  // x - y, carry flag = borrow
    localparam logic [2:0] FN_ADD   = 3'b010;  // x + y, carry flag = carry-out
    localparam logic [2:0] FN_MULHI = 3'b011;  // upper half of x*y (multi-cycle)
    localparam logic [2:0] FN_MULLO = 3'b100;  // lower half of x*y (multi-cycle)
    localparam logic [2:0] FN_XOR   = 3'b101;
    localparam logic [2:0] FN_AND   = 3'b110;
    localparam logic [2:0] FN_NOT   = 3'b111;  // ~x, or hold r when ir_nibble[3]=1

    // data_bus source select codes; 10..15 drive zero
    localparam logic [3:0] SRC_X0   = 4'd0;
    localparam logic [3:0] SRC_X1   = 4'd1;
    localparam logic [3:0] SRC_Y0   = 4'd2;
    localparam logic [3:0] SRC_Y1   = 4'd3;
    localparam logic [3:0] SRC_R    = 4'd4;
    localparam logic [3:0] SRC_M    = 4'd5;
    localparam logic [3:0] SRC_I    = 4'd6;
    localparam logic [3:0] SRC_DM   = 4'd7;
    localparam logic [3:0] SRC_PM   = 4'd8;
    localparam logic [3:0] SRC_PINS = 4'd9;

    // reg_en bit indices (bit 7 is unused)
    localparam int EN_X0   = 0;
    localparam int EN_X1   = 1;
    localparam int EN_Y0   = 2;
    localparam int EN_Y1   = 3;
    localparam int EN_R    = 4;
    localparam int EN_M    = 5;
    localparam int EN_I    = 6;
    localparam int EN_OREG = 8;

    // Sequential multiplier state
    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_e;

    function automatic logic is_mul_fn(input logic [2:0] fn);
        return (fn == FN_MULHI) || (fn == FN_MULLO);
    endfunction

endpackage

// File: rtl/computational_unit_param_if.sv
// -----------------------------------------------------------------------------
// computational_unit_param_if
// Bundles every signal of the computational unit except clk/reset.
//   Decoder/memory side (driven by master): i_pins, dm, ir_nibble, source_sel,
//     reg_en, i_sel, x_sel, y_sel, acc_mode
//   Unit side (driven by slave): data_bus, x0, x1, y0, y1, r, m, i, o_reg,
//     r_eq_0, r_carry, from_CU, busy, done, mul_state (debug view of the
//     multiplier FSM)
// Multiply handshake: a multiply is accepted on a clock edge where
// reg_en[4]=1, the function is 011/100 and busy=0. busy is then high for
// exactly DATA_W cycles; done pulses for one cycle in the cycle where busy
// has just fallen and r holds the result. While busy, reg_en[4] is ignored.
// -----------------------------------------------------------------------------
interface computational_unit_param_if #(
    parameter int DATA_W = 4
);
    import cu_pkg::*;

    logic [DATA_W-1:0]   i_pins;
    logic [DATA_W-1:0]   dm;
    logic [3:0]          ir_nibble;
    logic [3:0]          source_sel;
    logic [8:0]          reg_en;
    logic                i_sel;
    logic                x_sel;
    logic                y_sel;
    logic                acc_mode;

    logic [DATA_W-1:0]   data_bus;
    logic [DATA_W-1:0]   x0;
    logic [DATA_W-1:0]   x1;
    logic [DATA_W-1:0]   y0;
    logic [DATA_W-1:0]   y1;
    logic [DATA_W-1:0]   r;
    logic [DATA_W-1:0]   m;
    logic [DATA_W-1:0]   i;
    logic [DATA_W-1:0]   o_reg;
    logic                r_eq_0;
    logic                r_carry;
    logic [2*DATA_W-1:0] from_CU;
    logic                busy;
    logic                done;
    mul_state_e          mul_state;

    modport master (
        output i_pins, dm, ir_nibble, source_sel, reg_en,
               i_sel, x_sel, y_sel, acc_mode,
        input  data_bus, x0, x1, y0, y1, r, m, i, o_reg,
               r_eq_0, r_carry, from_CU, busy, done, mul_state
    );

    modport slave (
        input  i_pins, dm, ir_nibble, source_sel, reg_en,
               i_sel, x_sel, y_sel, acc_mode,
        output data_bus, x0, x1, y0, y1, r, m, i, o_reg,
               r_eq_0, r_carry, from_CU, busy, done, mul_state
    );

endinterface

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Shift-add multiplier, one partial-product bit per cycle.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (aborts a run)
//   i_start    accepted only while idle; latches i_x, i_y, i_hi
//   i_hi       1: result is upper half of product, 0: lower half
//   i_x, i_y   operands (DATA_W)
//   o_busy     high while iterating (MUL_CYC cycles)
//   o_fire     high during the final iteration; o_result is valid then and
//              the parent writes it at the end of that cycle
//   o_result   selected product half (DATA_W)
//   o_state    FSM state for debug
// MUL_CYC must equal DATA_W: each iteration consumes one multiplier bit.
// -----------------------------------------------------------------------------
module seq_multiplier
    import cu_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int MUL_CYC = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_hi,
    input  logic [DATA_W-1:0] i_x,
    input  logic [DATA_W-1:0] i_y,
    output logic              o_busy,
    output logic              o_fire,
    output logic [DATA_W-1:0] o_result,
    output mul_state_e        o_state
);

    localparam int CNT_W = $clog2(MUL_CYC + 1);

    mul_state_e            r_state;
    mul_state_e            w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_mcand;
    logic [2*DATA_W-1:0]   r_acc;
    logic                  r_hi;

    logic [DATA_W:0]       w_part;
    logic [2*DATA_W-1:0]   w_acc_next;
    logic                  w_last;
    logic                  w_load;

    // Accumulator holds {partial high, remaining multiplier bits}. The low
    // bit decides whether the multiplicand is added into the high half, then
    // the whole thing (including the add's carry) shifts right by one.
    always_comb begin
        w_part     = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
                   + (r_acc[0] ? {1'b0, r_mcand} : {(DATA_W+1){1'b0}});
        w_acc_next = {w_part, r_acc[DATA_W-1:1]};
    end

    assign w_last = (r_cnt == CNT_W'(MUL_CYC - 1));
    assign w_load = i_start && (r_state == MUL_IDLE);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MUL_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and outputs
    always_comb begin
        w_state_next = r_state;
        o_fire       = 1'b0;
        case (r_state)
            MUL_IDLE: begin
                if (i_start) begin
                    w_state_next = MUL_RUN;
                end
            end
            MUL_RUN: begin
                if (w_last) begin
                    w_state_next = MUL_IDLE;
                    o_fire       = 1'b1;
                end
            end
            default: w_state_next = MUL_IDLE;
        endcase
    end

    // Operand latches, accumulator and iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_hi    <= 1'b0;
        end else if (w_load) begin
            r_cnt   <= '0;
            r_mcand <= i_x;
            r_acc   <= {{DATA_W{1'b0}}, i_y};
            r_hi    <= i_hi;
        end else if (r_state == MUL_RUN) begin
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_busy   = (r_state == MUL_RUN);
    assign o_result = r_hi ? w_acc_next[2*DATA_W-1:DATA_W] : w_acc_next[DATA_W-1:0];
    assign o_state  = r_state;

endmodule

// File: rtl/computational_unit_param.sv
// -----------------------------------------------------------------------------
// computational_unit_param
// Datapath of the small microprocessor: register file (x0, x1, y0, y1, r, m,
// i, o_reg), internal data_bus mux, single-cycle ALU with zero/carry flags
// and a multi-cycle shift-add multiplier.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    computational_unit_param_if.slave (decoder controls in, registers,
//          data_bus, flags and multiply busy/done out)
// -----------------------------------------------------------------------------
module computational_unit_param
    import cu_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int MUL_CYC = DATA_W
) (
    input  logic                            clk,
    input  logic                            reset,
    computational_unit_param_if.slave       bus
);

    localparam logic [DATA_W-1:0] ZERO = '0;

    logic [DATA_W-1:0] r_x0, r_x1, r_y0, r_y1, r_r, r_m, r_i, r_o;
    logic              r_eq0;
    logic              r_carry;
    logic              r_done;

    logic [DATA_W-1:0] w_bus;
    logic [DATA_W-1:0] w_x;
    logic [DATA_W-1:0] w_y;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_alu;
    logic              w_alu_c;
    logic [2:0]        w_fn;
    logic              w_is_mul;
    logic              w_r_wr;
    logic              w_mul_start;
    logic              w_mul_busy;
    logic              w_mul_fire;
    logic [DATA_W-1:0] w_mul_result;
    mul_state_e        w_mul_state;
    logic              w_unused;

    assign w_fn     = bus.ir_nibble[2:0];
    assign w_is_mul = is_mul_fn(w_fn);
    assign w_unused = bus.reg_en[7];

    // reg_en[4] is owned by the multiplier while it runs: no r write, no restart.
    assign w_r_wr      = bus.reg_en[EN_R] && !w_mul_busy && !w_is_mul;
    assign w_mul_start = bus.reg_en[EN_R] && !w_mul_busy &&  w_is_mul;

    // data_bus source mux
    always_comb begin
        w_bus = ZERO;
        case (bus.source_sel)
            SRC_X0:   w_bus = r_x0;
            SRC_X1:   w_bus = r_x1;
            SRC_Y0:   w_bus = r_y0;
            SRC_Y1:   w_bus = r_y1;
            SRC_R:    w_bus = r_r;
            SRC_M:    w_bus = r_m;
            SRC_I:    w_bus = r_i;
            SRC_DM:   w_bus = bus.dm;
            SRC_PM:   w_bus = DATA_W'(bus.ir_nibble);
            SRC_PINS: w_bus = bus.i_pins;
            default:  w_bus = ZERO;
        endcase
    end

    assign w_x = bus.x_sel ? r_x1 : r_x0;
    assign w_y = bus.y_sel ? r_y1 : r_y0;

    // Single-cycle ALU. The extra top bit of w_diff is the borrow (x<y).
    always_comb begin
        w_sum   = {1'b0, w_x} + {1'b0, w_y};
        w_diff  = {1'b0, w_x} - {1'b0, w_y};
        w_alu   = r_r;
        w_alu_c = 1'b0;
        case (w_fn)
            FN_NEG:  w_alu = bus.ir_nibble[3] ? r_r : (ZERO - w_x);
            FN_SUB:  begin
                w_alu   = w_diff[DATA_W-1:0];
                w_alu_c = w_diff[DATA_W];
            end
            FN_ADD:  begin
                w_alu   = w_sum[DATA_W-1:0];
                w_alu_c = w_sum[DATA_W];
            end
            FN_XOR:  w_alu = w_x ^ w_y;
            FN_AND:  w_alu = w_x & w_y;
            FN_NOT:  w_alu = bus.ir_nibble[3] ? r_r : ~w_x;
            default: w_alu = r_r;
        endcase
    end

    seq_multiplier #(
        .DATA_W  (DATA_W),
        .MUL_CYC (MUL_CYC)
    ) u_mul (
        .clk      (clk),
        .rst      (reset),
        .i_start  (w_mul_start),
        .i_hi     (w_fn == FN_MULHI),
        .i_x      (w_x),
        .i_y      (w_y),
        .o_busy   (w_mul_busy),
        .o_fire   (w_mul_fire),
        .o_result (w_mul_result),
        .o_state  (w_mul_state)
    );

    // Architectural registers and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x0    <= ZERO;
            r_x1    <= ZERO;
            r_y0    <= ZERO;
            r_y1    <= ZERO;
            r_r     <= ZERO;
            r_m     <= ZERO;
            r_i     <= ZERO;
            r_o     <= ZERO;
            r_eq0   <= 1'b1;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (bus.reg_en[EN_X0])   r_x0 <= w_bus;
            if (bus.reg_en[EN_X1])   r_x1 <= w_bus;
            if (bus.reg_en[EN_Y0])   r_y0 <= w_bus;
            if (bus.reg_en[EN_M])    r_m  <= w_bus;
            if (bus.reg_en[EN_OREG]) r_o  <= w_bus;
            if (bus.reg_en[EN_I])    r_i  <= bus.i_sel ? (r_i + r_m) : w_bus;
            if (bus.reg_en[EN_Y1])   r_y1 <= bus.acc_mode ? (r_y1 + w_bus) : w_bus;

            // Multiply completion and ALU writes are mutually exclusive:
            // w_r_wr is blocked while the multiplier is busy.
            if (w_mul_fire) begin
                r_r     <= w_mul_result;
                r_eq0   <= (w_mul_result == ZERO);
                r_carry <= 1'b0;
            end else if (w_r_wr) begin
                r_r     <= w_alu;
                r_eq0   <= (w_alu == ZERO);
                r_carry <= w_alu_c;
            end

            r_done <= w_mul_fire;
        end
    end

    assign bus.data_bus  = w_bus;
    assign bus.x0        = r_x0;
    assign bus.x1        = r_x1;
    assign bus.y0        = r_y0;
    assign bus.y1        = r_y1;
    assign bus.r         = r_r;
    assign bus.m         = r_m;
    assign bus.i         = r_i;
    assign bus.o_reg     = r_o;
    assign bus.r_eq_0    = r_eq0;
    assign bus.r_carry   = r_carry;
    assign bus.from_CU   = {r_x1, r_x0};
    assign bus.busy      = w_mul_busy;
    assign bus.done      = r_done;
    assign bus.mul_state = w_mul_state;

endmodule
